// File: rtl/if_id_buffer.sv
// Fetch-side decoupling stage: issues instruction-memory reads under a credit
// check and queues the returned {pc, inst} pairs for the decode stage.
module if_id_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  output logic        pc_stall,
  output logic        imem_ce,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned XW = AW + 2;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic          inflight_q, inflight_d, drop_q, drop_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic          pop_s, push_s, can_issue_s;
  logic [XW-1:0] credit_s;

  // Handshake, credit check and head presentation; credit sees this cycle's pop
  always_comb begin
    id_valid    = (count_q != {CW{1'b0}});
    pop_s       = id_valid & id_ready;
    credit_s    = XW'(count_q) + XW'(inflight_q) - XW'(pop_s);
    can_issue_s = (credit_s < DEPTH_X);
    imem_ce     = ce & can_issue_s & ~flush & ~rst;
    pc_stall    = ce & ~can_issue_s & ~flush;
    imem_addr   = pc;
    push_s      = inflight_q & ~drop_q & ~flush;
    if (id_valid) begin
      id_pc   = pc_mem_q[head_q];
      id_inst = inst_mem_q[head_q];
    end else begin
      id_pc   = 32'h0000_0000;
      id_inst = NOP_INST;
    end
  end

  // Next-state: response capture, pointer/count update and flush
  always_comb begin
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    pc_mem_d     = pc_mem_q;
    inst_mem_d   = inst_mem_q;
    inflight_d   = imem_ce;
    pending_pc_d = imem_ce ? pc : pending_pc_q;
    drop_d       = flush & inflight_q;
    if (flush) begin
      count_d = {CW{1'b0}};
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
    end else begin
      if (push_s) begin
        pc_mem_d[tail_q]   = pending_pc_q;
        inst_mem_d[tail_q] = imem_inst;
        tail_d             = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= {CW{1'b0}};
      head_q       <= {AW{1'b0}};
      tail_q       <= {AW{1'b0}};
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      pending_pc_q <= 32'h0000_0000;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= 32'h0000_0000;
        inst_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      pending_pc_q <= pending_pc_d;
      pc_mem_q     <= pc_mem_d;
      inst_mem_q   <= inst_mem_d;
    end
  end
endmodule
